// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with 8N1 framing by default. It can also drive a
// BREAK, which holds the line low for one whole frame and then for the stop bits.
//
// Ports:
//   clk            system clock; all logic runs on its rising edge
//   rst            synchronous, active-high reset
//   uart_tx_en     send request, sampled every cycle while idle
//   uart_tx_data   byte to send, latched only on acceptance
//   uart_tx_break  BREAK request; wins over uart_tx_en in the same cycle
//   uart_tx_busy   high while a frame or BREAK is in progress (registered)
//   uart_txd       serial line, idle high (registered)
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_break,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int FRAME_BITS     = 1 + PAYLOAD_BITS + STOP_BITS;
    localparam int IDX_W          = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] BREAK_LAST = IDX_W'(FRAME_BITS - 1);

    if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_payload
        $error("uart_tx: PAYLOAD_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CYCLES_PER_BIT < 1) begin : g_bad_rate
        $error("uart_tx: CLK_HZ must be at least BIT_RATE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;    // cycle within the current bit
    logic [IDX_W-1:0]        idx_q, idx_d;    // bit index within DATA/STOP/BREAK
    logic [PAYLOAD_BITS-1:0] sh_q, sh_d;      // LSB is the bit on the line in DATA
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    bit_end;

    assign bit_end      = (cnt_q == CNT_LAST);
    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;

    // txd_d is only changed on a bit boundary or on acceptance, so the
    // registered line cannot glitch between boundaries.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        // The counter restarts at every boundary, so each bit lasts exactly
        // CYCLES_PER_BIT cycles and no drift builds up.
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (uart_tx_break) begin
                    state_d = S_BREAK;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (uart_tx_en) begin
                    state_d = S_START;
                    sh_d    = uart_tx_data;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = sh_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        // Busy drops on the edge that enters IDLE.
                        state_d = S_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_BREAK: begin
                // Low for a full frame's worth of bits, then the normal stop bits.
                if (bit_end) begin
                    if (idx_q == BREAK_LAST) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. The bench uses 8 clocks per bit
// and 8N1 framing. A line decoder compares each frame or BREAK it sees with
// the next entry in the expected queue.
module tb_uart_tx;

    localparam int CPB   = 8;                 // CLK_HZ / BIT_RATE below
    localparam int P     = 8;
    localparam int S     = 1;
    localparam int FRAME = (1 + P + S) * CPB; // busy length of one frame

    typedef struct {
        logic       brk;
        logic [7:0] data;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic       brk;
    logic       busy;
    logic       txd;

    item_t      sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         mst = 0;

    uart_tx #(.BIT_RATE(10), .CLK_HZ(80), .PAYLOAD_BITS(P), .STOP_BITS(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_tx_en   (en),
        .uart_tx_data (data),
        .uart_tx_break(brk),
        .uart_tx_busy (busy),
        .uart_txd     (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic b, input logic [7:0] d);
        item_t it;
        it.brk  = b;
        it.data = d;
        sb_q.push_back(it);
    endtask

    // Count the cycles busy stays high. The current sample is already busy.
    task automatic busy_len(input string tag, input int exp);
        int n;
        n = 1;
        while (busy && n < 2000) begin
            tick;
            if (busy) n++;
        end
        chk(tag, n, exp);
    endtask

    task automatic wait_level(input string tag, input logic lvl);
        int n;
        n = 0;
        while (busy !== lvl && n < 2000) begin
            tick;
            n++;
        end
        if (busy !== lvl) chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick;
            if (busy || !txd) n++;
        end
        chk(tag, n, 0);
    endtask

    // Line decoder: samples each bit at its midpoint. A low stop bit means
    // BREAK, and the decoder then measures how long the line stays low.
    initial begin
        int         mpos;
        int         k;
        logic [7:0] sh;
        item_t      it;
        mpos = 0;
        sh   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mst = 0;
            end else begin
                case (mst)
                    0: if (!txd) begin
                        mst  = 1;
                        mpos = 0;
                        sh   = '0;
                    end
                    1: begin
                        mpos++;
                        k = mpos / CPB;
                        if (mpos % CPB == CPB / 2) begin
                            if (k == 0) chk("start_mid", 32'(txd), 0);
                            else if (k <= P) sh[k-1] = txd;
                            else begin
                                if (sb_q.size() == 0) begin
                                    chk("sb_unexpected", 1, 0);
                                    mst = txd ? 0 : 3;
                                end else begin
                                    it = sb_q.pop_front();
                                    if (txd) begin
                                        chk("frame_is_data", 32'(it.brk), 0);
                                        chk("frame_data", 32'(sh), 32'(it.data));
                                        mst = 0;
                                    end else begin
                                        chk("frame_is_break", 32'(it.brk), 1);
                                        mst = 2;
                                    end
                                end
                            end
                        end
                    end
                    2: begin
                        mpos++;
                        if (txd) begin
                            chk("break_low_len", mpos, FRAME);
                            mst = 0;
                        end else if (mpos > 4 * FRAME) begin
                            chk("break_timeout", 1, 0);
                            mst = 0;
                        end
                    end
                    default: if (txd) mst = 0;
                endcase
            end
        end
    end

    initial begin
        int t1;
        int t2;
        int idle_n;
        rst  = 1'b1;
        en   = 1'b0;
        brk  = 1'b0;
        data = 8'h00;
        repeat (3) tick;
        chk("rst_txd", 32'(txd), 1);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick;
            chk("idle_txd", 32'(txd), 1);
            chk("idle_busy", 32'(busy), 0);
        end

        // Single frame 0xA5. The data changes after acceptance.
        en = 1'b1; data = 8'hA5; push(1'b0, 8'hA5);
        tick;
        en = 1'b0; data = 8'h00;
        chk("a5_acc_busy", 32'(busy), 1);
        chk("a5_acc_txd", 32'(txd), 0);
        busy_len("a5_busy_len", FRAME);
        repeat (5) tick;

        // Back-to-back frames with en held high: 0x00 and then 0xFF.
        en = 1'b1; data = 8'h00; push(1'b0, 8'h00);
        tick;
        t1 = cyc;
        data = 8'hFF; push(1'b0, 8'hFF);
        wait_level("b2b_fall_timeout", 1'b0);
        idle_n = 0;
        while (!busy && idle_n < 100) begin
            idle_n++;
            tick;
        end
        t2 = cyc;
        en = 1'b0;
        chk("b2b_idle_cycles", idle_n, 1);
        chk("b2b_period", t2 - t1, FRAME + 1);
        wait_level("b2b_end_timeout", 1'b0);
        repeat (5) tick;

        // A request while busy in DATA is dropped.
        en = 1'b1; data = 8'h5A; push(1'b0, 8'h5A);
        tick;
        en = 1'b0;
        repeat (30) tick;
        en = 1'b1; data = 8'h3C;
        tick;
        en = 1'b0;
        chk("ign_busy", 32'(busy), 1);
        wait_level("ign_timeout", 1'b0);
        quiet("ign_no_refire", 200);

        // BREAK and en together: BREAK wins.
        en = 1'b1; brk = 1'b1; data = 8'h77; push(1'b1, 8'h00);
        tick;
        en = 1'b0; brk = 1'b0;
        chk("brk_acc_busy", 32'(busy), 1);
        chk("brk_acc_txd", 32'(txd), 0);
        busy_len("brk_busy_len", FRAME + S * CPB);
        quiet("brk_no_frame", 200);

        // A held BREAK re-triggers after one idle cycle.
        brk = 1'b1; push(1'b1, 8'h00); push(1'b1, 8'h00);
        tick;
        t1 = cyc;
        wait_level("hbrk_fall_timeout", 1'b0);
        wait_level("hbrk_rise_timeout", 1'b1);
        t2 = cyc;
        brk = 1'b0;
        chk("hbrk_period", t2 - t1, FRAME + S * CPB + 1);
        wait_level("hbrk_end_timeout", 1'b0);
        repeat (5) tick;

        // Reset during bit 4 of a 0x0F frame, then send a clean frame.
        en = 1'b1; data = 8'h0F;
        tick;
        en = 1'b0;
        repeat (41) tick;
        chk("mid_bit4_txd", 32'(txd), 0);
        rst = 1'b1;
        tick;
        chk("midrst_txd", 32'(txd), 1);
        chk("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick;
        chk("post_rst_txd", 32'(txd), 1);
        en = 1'b1; data = 8'hC3; push(1'b0, 8'hC3);
        tick;
        en = 1'b0;
        chk("c3_acc_txd", 32'(txd), 0);
        busy_len("c3_busy_len", FRAME);

        for (int i = 0; i < 200 && (sb_q.size() != 0 || mst != 0); i++) tick;
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 by default. It is the companion to the existing UART receiver in the GPIO/instruction-loader wrapper. It serialises one byte per request onto `uart_txd` and can also emit a BREAK condition. It sits beside the receiver in the wrapper, so the core can echo loaded bytes or report status to the host at the same bit rate.

Parameters:
- BIT_RATE, 9600: line bit rate in bits/s.
- CLK_HZ, 50000000: frequency of `clk` in Hz.
- PAYLOAD_BITS, 8: data bits per frame, range 5-8.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_tx_en  in  1  send request; sampled every cycle.
- uart_tx_data  in  PAYLOAD_BITS  byte to send; sampled only on acceptance.
- uart_tx_break  in  1  BREAK request.
- uart_tx_busy  out  1  high while a frame or BREAK is in progress.
- uart_txd  out  1  serial line; idle high.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high.
- Bit timing:
  - CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer division (5208 at defaults).
  - Bit counter width = clog2(CYCLES_PER_BIT+1).
  - Every bit period is exactly CYCLES_PER_BIT cycles; no drift accumulates across bits.
- All outputs are registered.
- Reset:
  - On the cycle after `rst`=1 is sampled: `uart_txd`=1, `uart_tx_busy`=0, FSM=IDLE, counters=0, shift register=0.
  - Reset mid-frame or mid-BREAK aborts it; the line returns high on the next edge. No partial bits resume.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE:
    - `uart_txd`=1, `uart_tx_busy`=0.
    - If `uart_tx_break`=1 → BREAK. BREAK has priority when asserted in the same cycle as `uart_tx_en`.
    - Else if `uart_tx_en`=1 → latch `uart_tx_data` into the shift register and go to START.
  - START: `uart_txd`=0 for CYCLES_PER_BIT cycles, then → DATA.
  - DATA:
    - Sends PAYLOAD_BITS bits, LSB first, each for CYCLES_PER_BIT cycles.
    - Shifts right at each bit boundary; then → STOP.
  - STOP: `uart_txd`=1 for STOP_BITS*CYCLES_PER_BIT cycles, then → IDLE.
  - BREAK:
    - `uart_txd`=0 for (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles.
    - Then STOP (line high for STOP_BITS bit periods), then IDLE.
- Latency and busy:
  - Acceptance happens at the edge where IDLE samples the request.
  - At that same edge `uart_tx_busy` goes to 1 and `uart_txd` goes to 0, so the start bit begins one cycle after the request is presented.
  - `uart_tx_busy` returns to 0 on the edge that enters IDLE.
- Handshake:
  - `uart_tx_en` and `uart_tx_break` are ignored while busy. They are not queued.
  - Changes to `uart_tx_data` after acceptance do not affect the frame in flight.
- Back-to-back sends:
  - With `uart_tx_en` held high, the FSM spends exactly one IDLE cycle between frames.
  - Frame-to-frame period = (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT + 1 cycles (52081 at defaults).
- A level-held `uart_tx_break` re-triggers BREAK after each completion, with the same single IDLE cycle between BREAKs.
- No glitches on `uart_txd`: it changes only at bit boundaries or at reset.

Test Plan:
- Defaults, reset then idle 100 cycles → `uart_txd`=1 and `uart_tx_busy`=0 throughout.
- `uart_tx_en`=1 for one cycle with data 0xA5 → start bit low 5208 cycles, then bits 1,0,1,0,0,1,0,1 at 5208 cycles each, stop high 5208 cycles. `uart_tx_busy` high for 52080 cycles. The existing receiver looped back on the line reports `uart_rx_data`=0xA5 with `uart_rx_valid` pulsed.
- `uart_tx_en` held high, data 0x00 then 0xFF presented on consecutive acceptances → exactly one IDLE cycle between frames. Falling edges of the two start bits are 52081 cycles apart. Loopback receiver returns 0x00 then 0xFF.
- `uart_tx_en` pulsed while busy mid-DATA with data 0x3C → ignored; the current frame completes unchanged and no second frame follows.
- `uart_tx_break` and `uart_tx_en` asserted together in IDLE → line low for 52080 cycles, then high for 5208 cycles; no data frame is sent. Loopback receiver asserts `uart_rx_break`.
- `rst`=1 pulsed at bit 4 of a 0x0F frame → `uart_txd`=1 and `uart_tx_busy`=0 on the next edge. A new request after reset transmits a clean full frame.
